// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, settle, count synchronized
// oscillator rising edges over a gate window, then publish with a done pulse.
module ro_meas_ctrl #(
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_in,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 2;
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t             state, state_nx;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic [GATE_W-1:0]  gate_q;
    logic [CNT_W-1:0]   acc;
    logic               ovf;
    logic               s1, s2, s3;
    logic               ro_edge;
    logic               accept;

    assign ro_edge = s2 & ~s3;
    assign accept  = (state == IDLE) && start && !abort;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SETTLE;
                    tmr_nx   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (tmr == '0) begin
                    if (gate_q == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = GATE;
                        tmr_nx   = TMR_W'(gate_q) - TMR_W'(1);
                    end
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            GATE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (tmr == '0) begin
                    state_nx = DONE;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            gate_q   <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            ro_en    <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
            s1    <= ro_in;
            s2    <= s1;
            s3    <= s2;
            // Registered enable follows the state being entered, so it is low in DONE.
            ro_en <= (state_nx == SETTLE) || (state_nx == GATE);
            done  <= (state == DONE);
            if (accept) begin
                gate_q <= gate_cycles;
                acc    <= '0;
                ovf    <= 1'b0;
            end
            if ((state == GATE) && ro_edge) begin
                if (&acc) begin
                    ovf <= 1'b1;
                end else begin
                    acc <= acc + CNT_W'(1);
                end
            end
            if (state == DONE) begin
                count    <= acc;
                overflow <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: a 16-bit instance and a 4-bit saturating
// instance, each fed a period-4 square wave that starts when its ro_en rises.
module tb_ro_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_n, abort_n, ro_in_n, ro_en_n, busy_n, done_n, overflow_n;
    logic [15:0] gate_n, count_n;
    logic        start_s, abort_s, ro_in_s, ro_en_s, busy_s, done_s, overflow_s;
    logic [15:0] gate_s;
    logic [3:0]  count_s;
    logic [1:0]  ph_n, ph_s;

    typedef struct {
        int unsigned cnt;
        bit          ovf;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ro_meas_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start_n), .abort(abort_n),
        .gate_cycles(gate_n), .ro_in(ro_in_n), .ro_en(ro_en_n),
        .busy(busy_n), .done(done_n), .count(count_n), .overflow(overflow_n)
    );

    ro_meas_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYC(8)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
        .gate_cycles(gate_s), .ro_in(ro_in_s), .ro_en(ro_en_s),
        .busy(busy_s), .done(done_s), .count(count_s), .overflow(overflow_s)
    );

    // Oscillator model: phase counter runs only while enabled; high on phases 2,3.
    always @(posedge clk) begin
        ph_n <= ro_en_n ? ph_n + 2'd1 : 2'd0;
        ph_s <= ro_en_s ? ph_s + 2'd1 : 2'd0;
    end
    assign ro_in_n = ro_en_n & ph_n[1];
    assign ro_in_s = ro_en_s & ph_s[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sat, input bit st, input bit ab, input logic [15:0] g);
        if (sat) begin
            start_s = st; abort_s = ab; gate_s = g;
        end else begin
            start_n = st; abort_n = ab; gate_n = g;
        end
    endtask

    // One measurement: start sampled at edge 0, optional second start pulse
    // (gate 7) at cycle pulse_cyc that must be ignored.
    task automatic measure(input bit sat, input logic [15:0] g, input int exp_cyc,
                           input int unsigned exp_cnt, input bit exp_ovf, input int pulse_cyc);
        exp_t e;
        int   cyc;
        bit   got;
        int   bad_en, bad_busy, extra;
        logic d, en, b;
        logic [15:0] cnt;
        logic ov;
        sb.push_back('{exp_cnt, exp_ovf, exp_cyc});
        drive(sat, 1'b1, 1'b0, g);
        step();
        drive(sat, 1'b0, 1'b0, g);
        cyc = 1; got = 0; bad_en = 0; bad_busy = 0;
        while (!got && cyc <= 1000) begin
            if (cyc == pulse_cyc)     drive(sat, 1'b1, 1'b0, 16'd7);
            if (cyc == pulse_cyc + 1) drive(sat, 1'b0, 1'b0, 16'd7);
            d   = sat ? done_s  : done_n;
            en  = sat ? ro_en_s : ro_en_n;
            b   = sat ? busy_s  : busy_n;
            cnt = sat ? 16'(count_s) : count_n;
            ov  = sat ? overflow_s : overflow_n;
            if (en !== ((cyc >= 1) && (cyc <= exp_cyc - 2))) bad_en++;
            if (b  !== (cyc <= exp_cyc - 1)) bad_busy++;
            if (d === 1'b1) begin
                got = 1;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("count", 32'(cnt), e.cnt);
                    check("overflow", 32'(ov), 32'(e.ovf));
                end
            end else begin
                step();
                cyc++;
            end
        end
        check("done_seen", 32'(got), 1);
        check("ro_en_profile", bad_en, 0);
        check("busy_profile", bad_busy, 0);
        extra = 0;
        repeat (40) begin
            step();
            if ((sat ? done_s : done_n) !== 1'b0) extra++;
            if ((sat ? busy_s : busy_n) !== 1'b0) extra++;
        end
        check("post_quiet", extra, 0);
    endtask

    initial begin
        int unsigned last_cnt;
        int quiet;
        #20_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned last_cnt;
        int quiet;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'd0);
        drive(1, 1'b0, 1'b0, 16'd0);
        repeat (3) step();
        check("rst_ro_en", 32'(ro_en_n), 0);
        check("rst_busy", 32'(busy_n), 0);
        check("rst_done", 32'(done_n), 0);
        check("rst_count", 32'(count_n), 0);
        check("rst_overflow", 32'(overflow_n), 0);
        check("rst_sat_count", 32'(count_s), 0);
        rst = 1'b0;
        step();

        // Nominal, zero gate, and busy lockout on the 16-bit instance
        measure(0, 16'd100, 110, 25, 1'b0, -10);
        measure(0, 16'd0,   10,  0,  1'b0, -10);
        measure(0, 16'd50,  60,  13, 1'b0, 20);
        last_cnt = 13;

        // Saturation then recovery on the 4-bit instance
        measure(1, 16'd100, 110, 15, 1'b1, -10);
        measure(1, 16'd20,  30,  5,  1'b0, -10);

        // Abort at cycle 30
        drive(0, 1'b1, 1'b0, 16'd100);
        step();
        drive(0, 1'b0, 1'b0, 16'd100);
        repeat (29) step();
        drive(0, 1'b0, 1'b1, 16'd100);
        step();
        drive(0, 1'b0, 1'b0, 16'd100);
        check("abort_ro_en", 32'(ro_en_n), 0);
        check("abort_busy", 32'(busy_n), 0);
        quiet = 0;
        repeat (120) begin
            step();
            if (done_n !== 1'b0 || busy_n !== 1'b0) quiet++;
        end
        check("abort_no_done", quiet, 0);
        check("abort_count_held", 32'(count_n), last_cnt);

        // start and abort together in IDLE
        drive(0, 1'b1, 1'b1, 16'd100);
        step();
        drive(0, 1'b0, 1'b0, 16'd100);
        check("start_abort_busy", 32'(busy_n), 0);
        step();
        check("start_abort_ro_en", 32'(ro_en_n), 0);

        // Reset asserted in GATE (cycle 50)
        drive(0, 1'b1, 1'b0, 16'd100);
        step();
        drive(0, 1'b0, 1'b0, 16'd100);
        repeat (49) step();
        check("pre_rst_busy", 32'(busy_n), 1);
        rst = 1'b1;
        step();
        check("midrst_ro_en", 32'(ro_en_n), 0);
        check("midrst_busy", 32'(busy_n), 0);
        check("midrst_done", 32'(done_n), 0);
        check("midrst_count", 32'(count_n), 0);
        check("midrst_overflow", 32'(overflow_n), 0);
        rst = 1'b0;
        step();
        measure(0, 16'd100, 110, 25, 1'b0, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Measurement sequencer for the on-chip ring oscillator. It enables the oscillator, waits for a settle interval, then counts oscillator rising edges over a programmable gate window in the system clock domain. At the end of the window it stops the oscillator and publishes the result with a one-cycle done pulse. It sits between the tile's control inputs and the ring oscillator's `enable`/`osc_out` pins.

## Interface
- `CNT_W`, default 16: edge-counter and `count` width.
- `GATE_W`, default 16: `gate_cycles` width.
- `SETTLE_CYC`, default 8, minimum 3: clock cycles between `ro_en` rising and the gate opening.

Ports:
- `clk` input 1: system clock. The only clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a measurement. Sampled only in IDLE.
- `abort` input 1: cancel the measurement in progress.
- `gate_cycles` input GATE_W: gate length in `clk` cycles. Latched on an accepted `start`.
- `ro_in` input 1: ring oscillator output. Asynchronous to `clk`.
- `ro_en` output 1: oscillator enable, registered.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a result is published.
- `count` output CNT_W: last published edge count. Held between measurements.
- `overflow` output 1: the last published count saturated.

## Operation
- `ro_in` passes through a 2-FF synchronizer (`s1`, `s2`) and then a previous-sample register `s3`.
- A rising edge is detected when `s2 & ~s3`. Counting is valid for f_ro < f_clk/2. Faster oscillators alias, and this is documented, not detected.
- The state machine has four states: IDLE, SETTLE, GATE, DONE.
- IDLE:
  - `ro_en`=0 and `busy`=0.
  - `start`=1 (and `abort`=0): latch `gate_cycles` into `gate_q`, clear `acc` and `ovf`, load `tmr`=SETTLE_CYC-1, go to SETTLE.
- SETTLE:
  - `ro_en`=1. Edges are not counted.
  - Decrement `tmr`. When `tmr`=0:
    - `gate_q`=0: go to DONE.
    - Otherwise: load `tmr`=`gate_q`-1 and go to GATE.
- GATE:
  - `ro_en`=1. Each cycle with an edge detected, `acc` increments.
  - At all-ones, `acc` holds and `ovf` is set (sticky).
  - Decrement `tmr`. When `tmr`=0, go to DONE.
  - An edge detected in the final GATE cycle is counted.
- DONE (one cycle):
  - `ro_en`=0.
  - `count`<=`acc` and `overflow`<=`ovf`. The registered outputs update on the exit edge.
  - `done`=1 on the cycle the new `count` becomes visible. Then go to IDLE.
- `abort`=1 in SETTLE or GATE:
  - Next state is IDLE with `ro_en`=0.
  - No `done` pulse; `count` and `overflow` are unchanged.
  - `abort` in IDLE or DONE has no effect.
- If `start` and `abort` are both high in IDLE, `abort` wins and the measurement does not start.
- `start` while `busy`=1 is ignored. It is not queued.
- `gate_cycles` changes after acceptance do not affect the measurement in progress.

## Timing
- Reset values: state IDLE; `ro_en`, `busy`, `done`, `overflow` = 0; `count` = 0; `s1`, `s2`, `s3`, `acc`, `tmr` = 0.
- Reset in any state returns to IDLE on the next edge, with `ro_en` low in the following cycle.
- Let `start` be sampled at edge 0. Then:
  - `ro_en` and `busy` are high from cycle 1.
  - SETTLE occupies cycles 1..SETTLE_CYC.
  - GATE occupies the next `gate_cycles` cycles.
  - DONE is at cycle SETTLE_CYC+`gate_cycles`+1.
  - `done`, the new `count` and `busy`=0 appear at cycle SETTLE_CYC+`gate_cycles`+2.
- The earliest next `start` is sampled in the cycle `done` is high.
- Edge-detect latency is 3 cycles from `ro_in` to `s3`. The gate window therefore counts `ro_in` edges from roughly 2–3 cycles before GATE entry to 2–3 cycles before GATE exit. SETTLE_CYC≥3 guarantees the pipeline holds enabled-oscillator samples.

## Test plan
- Nominal: reset, then SETTLE_CYC=8, `gate_cycles`=100; the bench drives `ro_in` as a `clk`-synchronous square wave of period 4 that starts when `ro_en` rises. Require `count`=25, `overflow`=0, and `done` exactly at cycle 110 after `start`, high for one cycle.
- Saturation: CNT_W=4, `gate_cycles`=100, `ro_in` period 4. Require `count`=15 and `overflow`=1; a following run with `gate_cycles`=20 gives `count`=5 and `overflow`=0.
- Zero gate: `gate_cycles`=0. Require `done` at cycle SETTLE_CYC+2 (=10), `count`=0, `ro_en` high only in cycles 1..8.
- Busy lockout: `gate_cycles`=50; pulse `start` again at cycle 20 with `gate_cycles`=7. Require a single `done` at cycle 60, `count` reflecting a 50-cycle window (12 or 13 at period 4), and no second measurement.
- Abort: `gate_cycles`=100; `abort` at cycle 30. Require `ro_en`=0 and `busy`=0 at cycle 31, no `done`, and `count` equal to the previous value. Separately, `start` and `abort` together in IDLE keep `busy`=0.
- Reset mid-operation: assert `rst` during GATE. Require that at the next edge all outputs equal their reset values (`count`=0) and `ro_en`=0; a new `start` afterwards completes normally.
